la_trace_display: RTL

Four-channel logic-analyzer capture and render stage for the 640x480 VGA path. It samples a 4-bit trace input into an internal 128-entry buffer after a rising-edge trigger on a selected channel. It sits directly downstream of the VGA sync core, consuming its pixel coordinates, `video_on`, `hsync` and `vsync`, and emits pipeline-aligned 12-bit RGB plus delayed sync signals to the pins.

---
 rtl/la_trace_display_if.sv | 33 +++
 rtl/la_trace_display.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_trace_display_if.sv
`default_nettype none
// ============================================================================
// Module   : la_trace_display_if
// Brief    : Probe, capture-control and video bus for the logic-analyzer
//            capture and render stage.
// Revision : 1.0
// ============================================================================
interface la_trace_display_if;
    logic [3:0]  trace_in;
    logic        arm;
    logic [1:0]  trig_ch;
    logic [11:0] pixel_x;
    logic [11:0] pixel_y;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;
    logic        armed;
    logic        done;

    modport master (
        output trace_in, arm, trig_ch, pixel_x, pixel_y, video_on, hsync_in, vsync_in,
        input  rgb, hsync_out, vsync_out, armed, done
    );

    modport slave (
        input  trace_in, arm, trig_ch, pixel_x, pixel_y, video_on, hsync_in, vsync_in,
        output rgb, hsync_out, vsync_out, armed, done
    );
endinterface
`default_nettype wire

// File: rtl/la_trace_display.sv
`default_nettype none
// ============================================================================
// Module   : la_trace_display
// Brief    : Four-channel trace capture into a sample buffer with 640x480
//            waveform rendering, two-clock aligned to the sync core.
//            Optional grid overlay enabled by defining LA_GRID_EN.
// Revision : 1.0
// ============================================================================
module la_trace_display #(
    parameter int SAMPLES        = 128,
    parameter int PIX_PER_SAMPLE = 5,
    parameter int DIV            = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    la_trace_display_if.slave  bus
);

    localparam int c_iw = (SAMPLES > 1)        ? $clog2(SAMPLES)        : 1;
    localparam int c_sw = (PIX_PER_SAMPLE > 1) ? $clog2(PIX_PER_SAMPLE) : 1;
    localparam int c_cw = (DIV > 1)            ? $clog2(DIV)            : 1;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_armed   = 2'd1;
    localparam logic [1:0] c_st_capture = 2'd2;
    localparam logic [1:0] c_st_done    = 2'd3;

    localparam logic [11:0] c_h_active = 12'd640;
    localparam logic [11:0] c_v_active = 12'd480;

    // ------------------------------------------------------------------
    // Probe synchronizer and sample tick
    // ------------------------------------------------------------------
    logic [3:0]      r_ts_meta;
    logic [3:0]      r_ts;
    logic [c_cw-1:0] r_tick_cnt;
    logic            w_tick;

    assign w_tick = (r_tick_cnt == c_cw'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts_meta  <= '0;
            r_ts       <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_ts_meta  <= bus.trace_in;
            r_ts       <= r_ts_meta;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + c_cw'(1);
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [3:0]      r_prev;
    logic            r_prev_vld;
    logic [c_iw-1:0] r_wr_idx;
    logic            w_trig;
    logic            w_wr_en;
    logic [c_iw-1:0] w_wr_addr;
    logic [3:0]      r_mem [SAMPLES];

    // r_prev_vld suppresses a trigger on the first tick after arming
    assign w_trig = w_tick && r_prev_vld && !r_prev[bus.trig_ch] && r_ts[bus.trig_ch];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_wr_idx   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.arm) begin
                        r_state    <= c_st_armed;
                        r_prev_vld <= 1'b0;
                    end
                end
                c_st_armed: begin
                    if (w_tick) begin
                        r_prev     <= r_ts;
                        r_prev_vld <= 1'b1;
                        if (w_trig) begin
                            r_state  <= c_st_capture;
                            r_wr_idx <= c_iw'(1);
                        end
                    end
                end
                c_st_capture: begin
                    if (w_tick) begin
                        r_wr_idx <= r_wr_idx + c_iw'(1);
                        if (r_wr_idx == c_iw'(SAMPLES - 1))
                            r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    if (bus.arm) begin
                        r_state    <= c_st_armed;
                        r_prev_vld <= 1'b0;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign w_wr_en   = ((r_state == c_st_armed) && w_trig) ||
                       ((r_state == c_st_capture) && w_tick);
    assign w_wr_addr = (r_state == c_st_capture) ? r_wr_idx : '0;

    // Buffer survives reset and re-arm; the display shows whatever it holds
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[w_wr_addr] <= r_ts;
    end

    assign bus.armed = (r_state == c_st_armed);
    assign bus.done  = (r_state == c_st_done);

    // ------------------------------------------------------------------
    // Render stage 1: column counters, buffer read, band decode
    // ------------------------------------------------------------------
    logic            w_x_vis;
    logic            w_y_vis;
    logic [c_sw-1:0] r_sub;
    logic [c_iw-1:0] r_idx;
    logic [c_sw-1:0] w_cur_sub;
    logic [c_iw-1:0] w_cur_idx;
    logic [1:0]      w_band;
    logic [6:0]      w_base;
    logic [6:0]      w_row;

    assign w_x_vis   = (bus.pixel_x < c_h_active);
    assign w_y_vis   = (bus.pixel_y < c_v_active);
    // Counters describe the current column; pixel_x==0 restarts them combinationally
    assign w_cur_sub = (bus.pixel_x == 12'd0) ? '0 : r_sub;
    assign w_cur_idx = (bus.pixel_x == 12'd0) ? '0 : r_idx;

    // Row offsets only need 7 bits, so band bases are taken modulo 128
    always_comb begin
        w_band = 2'd3;
        w_base = 7'd104;
        if (bus.pixel_y < 12'd120) begin
            w_band = 2'd0;
            w_base = 7'd0;
        end else if (bus.pixel_y < 12'd240) begin
            w_band = 2'd1;
            w_base = 7'd120;
        end else if (bus.pixel_y < 12'd360) begin
            w_band = 2'd2;
            w_base = 7'd112;
        end
    end

    assign w_row = bus.pixel_y[6:0] - w_base;

    logic            r_s1_vis;
    logic [1:0]      r_s1_band;
    logic [6:0]      r_s1_row;
    logic [c_sw-1:0] r_s1_sub;
    logic [c_iw-1:0] r_s1_idx;
    logic [3:0]      r_s1_sample;
    logic [3:0]      r_s1_last;
    logic            r_hs_d;
    logic            r_vs_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub       <= '0;
            r_idx       <= '0;
            r_s1_vis    <= 1'b0;
            r_s1_band   <= '0;
            r_s1_row    <= '0;
            r_s1_sub    <= '0;
            r_s1_idx    <= '0;
            r_s1_sample <= '0;
            r_s1_last   <= '0;
            r_hs_d      <= 1'b1;
            r_vs_d      <= 1'b1;
        end else begin
            if (w_x_vis && w_y_vis) begin
                if (w_cur_sub == c_sw'(PIX_PER_SAMPLE - 1)) begin
                    r_sub <= '0;
                    r_idx <= (w_cur_idx == c_iw'(SAMPLES - 1)) ? '0 : w_cur_idx + c_iw'(1);
                end else begin
                    r_sub <= w_cur_sub + c_sw'(1);
                    r_idx <= w_cur_idx;
                end
            end
            r_s1_vis    <= bus.video_on && w_x_vis && w_y_vis;
            r_s1_band   <= w_band;
            r_s1_row    <= w_row;
            r_s1_sub    <= w_cur_sub;
            r_s1_idx    <= w_cur_idx;
            r_s1_sample <= r_mem[w_cur_idx];
            if (w_cur_sub == '0)
                r_s1_last <= r_s1_sample;
            r_hs_d      <= bus.hsync_in;
            r_vs_d      <= bus.vsync_in;
        end
    end

    // ------------------------------------------------------------------
    // Render stage 2: colour selection
    // ------------------------------------------------------------------
    logic        w_bit;
    logic        w_lbit;
    logic        w_trace;
    logic [11:0] w_colour;
    logic [11:0] w_rgb;
    logic [11:0] r_rgb;
    logic        r_hs_out;
    logic        r_vs_out;

    assign w_bit   = r_s1_sample[r_s1_band];
    assign w_lbit  = r_s1_last[r_s1_band];
    assign w_trace = (w_bit && (r_s1_row == 7'd30)) ||
                     (!w_bit && (r_s1_row == 7'd90)) ||
                     ((r_s1_sub == '0) && (r_s1_idx != '0) && (w_bit != w_lbit) &&
                      (r_s1_row >= 7'd30) && (r_s1_row <= 7'd90));

    always_comb begin
        case (r_s1_band)
            2'd0:    w_colour = 12'h0F0;
            2'd1:    w_colour = 12'hFF0;
            2'd2:    w_colour = 12'h0FF;
            default: w_colour = 12'hF0F;
        endcase
    end

`ifdef LA_GRID_EN
    logic w_grid;
    assign w_grid = ((r_s1_idx[2:0] == 3'd0) && (r_s1_sub == '0)) || (r_s1_row == 7'd0);

    always_comb begin
        w_rgb = 12'h000;
        if (r_s1_vis) begin
            if (w_trace)
                w_rgb = w_colour;
            else if (w_grid)
                w_rgb = 12'h333;
        end
    end
`else
    always_comb begin
        w_rgb = 12'h000;
        if (r_s1_vis && w_trace)
            w_rgb = w_colour;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb    <= '0;
            r_hs_out <= 1'b1;
            r_vs_out <= 1'b1;
        end else begin
            r_rgb    <= w_rgb;
            r_hs_out <= r_hs_d;
            r_vs_out <= r_vs_d;
        end
    end

    assign bus.rgb       = r_rgb;
    assign bus.hsync_out = r_hs_out;
    assign bus.vsync_out = r_vs_out;

endmodule
`default_nettype wire
